// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCodes, field positions and
// the packed SR/Cause layouts with helpers to convert to/from the 32-bit view.
package cp0_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned IM_W       = 6;
  localparam int unsigned EXC_W      = 5;

  localparam logic [REG_ADDR_W-1:0] SR_ADDR_DEF    = 5'd12;
  localparam logic [REG_ADDR_W-1:0] CAUSE_ADDR_DEF = 5'd13;
  localparam logic [REG_ADDR_W-1:0] EPC_ADDR_DEF   = 5'd14;

  localparam int unsigned SR_IE_BIT     = 0;
  localparam int unsigned SR_EXL_BIT    = 1;
  localparam int unsigned SR_IM_LSB     = 10;
  localparam int unsigned CAUSE_EXC_LSB = 2;
  localparam int unsigned CAUSE_IP_LSB  = 10;
  localparam int unsigned CAUSE_BD_BIT  = 31;

  typedef enum logic [EXC_W-1:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  typedef struct packed {
    logic [IM_W-1:0] im;
    logic            exl;
    logic            ie;
  } sr_t;

  typedef struct packed {
    logic            bd;
    logic [IM_W-1:0] ip;
    exc_code_e       exc_code;
  } cause_t;

  function automatic logic [XLEN-1:0] sr_word(input sr_t s);
    logic [XLEN-1:0] w;
    w = '0;
    w[SR_IM_LSB +: IM_W] = s.im;
    w[SR_EXL_BIT]        = s.exl;
    w[SR_IE_BIT]         = s.ie;
    return w;
  endfunction

  function automatic sr_t sr_from_word(input logic [XLEN-1:0] w);
    sr_t s;
    s.im  = w[SR_IM_LSB +: IM_W];
    s.exl = w[SR_EXL_BIT];
    s.ie  = w[SR_IE_BIT];
    return s;
  endfunction

  function automatic logic [XLEN-1:0] cause_word(input cause_t c);
    logic [XLEN-1:0] w;
    w = '0;
    w[CAUSE_BD_BIT]              = c.bd;
    w[CAUSE_IP_LSB +: IM_W]      = c.ip;
    w[CAUSE_EXC_LSB +: EXC_W]    = c.exc_code;
    return w;
  endfunction

endpackage

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC, exception/interrupt request generation,
// mtc0/mfc0 access and eret handling.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [XLEN-1:0]       EXC_VECTOR = 32'h0000_4180,
  parameter logic [REG_ADDR_W-1:0] SR_ADDR    = SR_ADDR_DEF,
  parameter logic [REG_ADDR_W-1:0] CAUSE_ADDR = CAUSE_ADDR_DEF,
  parameter logic [REG_ADDR_W-1:0] EPC_ADDR   = EPC_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]       wdata,
  output logic [XLEN-1:0]       rdata,
  input  logic [XLEN-1:0]       vpc,
  input  logic                  bd_in,
  input  logic                  exc_in,
  input  logic [EXC_W-1:0]      exc_code_in,
  input  logic [IM_W-1:0]       hwint,
  input  logic                  eret,
  output logic                  req,
  output logic [XLEN-1:0]       handler_pc,
  output logic [XLEN-1:0]       epc_out
);

  sr_t         sr_q, sr_d;
  cause_t      cause_q, cause_d;
  logic [29:0] epc_q, epc_d;
  logic        int_req, exc_req;
  logic [1:0]  unused_vpc;

  assign unused_vpc = vpc[1:0];

  // Requests are masked entirely while the handler runs (EXL set).
  always_comb begin
    int_req = (|(cause_q.ip & sr_q.im)) & sr_q.ie & ~sr_q.exl;
    exc_req = exc_in & ~sr_q.exl;
  end

  assign req        = int_req | exc_req;
  assign handler_pc = EXC_VECTOR;
  assign epc_out    = {epc_q, 2'b00};

  // Next-state: exception entry beats mtc0; eret clears EXL over an SR write.
  always_comb begin
    sr_d       = sr_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    cause_d.ip = hwint;
    if (req) begin
      sr_d.exl         = 1'b1;
      cause_d.exc_code = int_req ? EXC_INT : exc_code_e'(exc_code_in);
      cause_d.bd       = bd_in;
      epc_d            = bd_in ? (vpc[31:2] - 30'd1) : vpc[31:2];
    end else begin
      if (en && (addr == SR_ADDR)) begin
        sr_d = sr_from_word(wdata);
      end
      if (en && (addr == EPC_ADDR)) begin
        epc_d = wdata[31:2];
      end
      if (eret) begin
        sr_d.exl = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q    <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      sr_q    <= sr_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  // mfc0 read port shows the pre-edge register contents.
  always_comb begin
    rdata = '0;
    if (addr == SR_ADDR) begin
      rdata = sr_word(sr_q);
    end else if (addr == CAUSE_ADDR) begin
      rdata = cause_word(cause_q);
    end else if (addr == EPC_ADDR) begin
      rdata = {epc_q, 2'b00};
    end
  end

endmodule
